sample_playback: RTL and testbench
==================================

SAMPLE_PLAYBACK -- requirements
Module: sample_playback

Interface
REQ-001 Parameters SHALL be: SAMPLE_W, default 12, sample width; WORD_W, default 64, packed FIFO word width; LANES, default 4, 16-bit sample slots per word.
REQ-002 Ports SHALL be:
- clk  in  1  system clock; one clock domain only.
- rst_n  in  1  asynchronous, active-low reset.
- play_en  in  1  level-sensitive playback enable.
- play_len  in  32  number of samples to play, sampled at start.
- sample_tick  in  1  one-cycle sample-rate strobe.
- fifo_dout  in  WORD_W  packed word from source FIFO.
- fifo_empty  in  1  source FIFO empty.
- fifo_valid  in  1  fifo_dout valid, one cycle after fifo_rd_en (standard, non-FWFT FIFO).
- fifo_rd_en  out  1  read strobe to source FIFO.
- sample_out  out  SAMPLE_W  current sample.
- sample_valid  out  1  one-cycle pulse with each new sample_out.
- underrun  out  1  sticky; a tick was missed for lack of data.
- play_end  out  32  {31'b0, done}, status word.

Function
REQ-003 Unpacking: lane k SHALL be fifo_dout[16k+11:16k], k=0..LANES-1, played lane 0 first; bits [16k+15:16k+12] are ignored.
REQ-004 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-005 IDLE->RUN when play_en=1 and play_len!=0: latch remaining=play_len and words_to_fetch=ceil(play_len/LANES); clear underrun; lane=0.
REQ-006 If play_en=1 and play_len=0, the FSM SHALL go directly to DONE.
REQ-007 The block SHALL hold two word registers, cur and next, each with a full flag; the FIFO valid word SHALL always load next.
REQ-008 In RUN, fifo_rd_en SHALL be asserted for one cycle only when next is empty, no read is outstanding, fifo_empty=0 and words_to_fetch>0; words_to_fetch then decrements.
REQ-009 Only one read SHALL be outstanding at a time; fifo_rd_en SHALL never be asserted while fifo_empty=1.
REQ-010 When cur is empty and next is full, next SHALL move to cur in that cycle, setting lane=0.
REQ-011 On sample_tick in RUN with cur full, the next cycle SHALL show sample_out=cur lane and sample_valid=1, decrement remaining and increment lane.
REQ-012 When lane LANES-1 is consumed, cur SHALL become empty, or be refilled from next in the same cycle if next is full.
REQ-013 On sample_tick in RUN with cur empty: no sample_valid, remaining unchanged, underrun set to 1 and held until the next start.
REQ-014 When remaining reaches 0, the FSM SHALL enter DONE the following cycle; any remaining lanes in cur SHALL be discarded.
REQ-015 In DONE, play_end[0]=1; the FSM SHALL return to IDLE when play_en=0.
REQ-016 play_en=0 in RUN SHALL abort to IDLE next cycle, clearing both buffers and counters.
- An outstanding FIFO read returned after abort SHALL be discarded.
REQ-017 sample_tick outside RUN SHALL be ignored.
REQ-018 sample_out SHALL hold its last value between pulses.

Reset
REQ-019 On rst_n=0, the block SHALL asynchronously reset:
- state=IDLE.
- fifo_rd_en, sample_valid, underrun = 0.
- sample_out = 0.
- play_end = 0.
- cur, next full flags = 0.
- outstanding flag = 0.
- All counters = 0.
REQ-020 After reset deasserts, the block SHALL stay in IDLE until play_en is sampled high.

Structure
REQ-021 SAMPLE_W, WORD_W, LANES and the state encoding SHALL live in the shared DAQ package used by the capture-side packer.
REQ-022 The block SHALL be a single module with no sub-modules; the two-word buffer SHALL remain inline.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Basic: FIFO holds word 64'h0ABC_0123_0456_0789, play_len=4, tick every 10 cycles -> sample_out 12'h789, 12'h456, 12'h123, 12'hABC, each with one sample_valid pulse; then play_end=1; underrun=0.
- Partial word: play_len=6 with 2 words -> exactly 6 samples; exactly 2 fifo_rd_en pulses; lanes 2-3 of word 2 are never output.
- Underrun: FIFO empty after word 1, ticks continue -> 5th tick sets underrun=1 with no sample_valid. When a word is then pushed, playback resumes at lane 0 of word 2; the total sample count still equals play_len.
- Abort: play_en dropped after 3 samples, while a read is outstanding -> IDLE next cycle. The late fifo_valid is ignored; a restart with play_len=4 plays a fresh word from lane 0.
- Boundary: play_len=0 -> DONE immediately with no fifo_rd_en. Tick on the same cycle as the lane-3 consume with next full -> no lost sample and no gap.
- Reset mid-RUN: rst_n pulsed low -> all outputs go to 0 asynchronously; state=IDLE.

Source files
------------

// File: rtl/sample_playback_pkg.sv
// Shared DAQ definitions: sample/word geometry, playback state encoding
// and small sizing helpers used by the playback and capture-side blocks.
package sample_playback_pkg;

    localparam int SAMPLE_W_DEF = 12;   // bits per audio/ADC sample
    localparam int WORD_W_DEF   = 64;   // packed FIFO word width
    localparam int LANES_DEF    = 4;    // 16-bit sample slots per word
    localparam int LANE_W       = 16;   // slot pitch inside a packed word

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of an index able to address n items (never narrower than 1 bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Number of packed words needed to hold len samples, rounded up.
    // Computed in 33 bits so a len near 2^32 cannot wrap.
    function automatic logic [31:0] words_for(input logic [31:0] len, input int lanes);
        logic [32:0] sum;
        sum = {1'b0, len} + 33'(lanes - 1);
        return 32'(sum / 33'(lanes));
    endfunction

endpackage

// File: rtl/sample_playback.sv
// Sample playback engine: fetches packed words from a standard (non-FWFT)
// FIFO into a two-word buffer and releases one sample per sample_tick.
module sample_playback
    import sample_playback_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int WORD_W   = WORD_W_DEF,
    parameter int LANES    = LANES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                play_en,
    input  logic [31:0]         play_len,
    input  logic                sample_tick,
    input  logic [WORD_W-1:0]   fifo_dout,
    input  logic                fifo_empty,
    input  logic                fifo_valid,
    output logic                fifo_rd_en,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                underrun,
    output logic [31:0]         play_end
);

    localparam int LIDX_W = idx_w(LANES);
    localparam int BUF_W  = LANES * SAMPLE_W;
    localparam logic [LIDX_W-1:0] LANE_LAST = LIDX_W'(LANES - 1);

    state_e                state_q, state_d;
    logic [31:0]           remaining_q, remaining_d;
    logic [31:0]           fetch_q, fetch_d;
    logic [LIDX_W-1:0]     lane_q, lane_d;
    logic [BUF_W-1:0]      cur_q, cur_d;
    logic [BUF_W-1:0]      next_q, next_d;
    logic                  cur_full_q, cur_full_d;
    logic                  next_full_q, next_full_d;
    logic                  pend_q, pend_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic                  valid_q, valid_d;
    logic                  underrun_q, underrun_d;

    logic [BUF_W-1:0]      fifo_samples;
    logic [SAMPLE_W-1:0]   cur_lane [LANES];
    logic                  start;
    logic                  run_ok;
    logic                  unused_fifo_bits;

    // Strip the unused top nibble of each 16-bit slot on the way in, and
    // expose the current word as an array of lanes for the output mux.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign fifo_samples[gi*SAMPLE_W +: SAMPLE_W] = fifo_dout[gi*LANE_W +: SAMPLE_W];
            assign cur_lane[gi] = cur_q[gi*SAMPLE_W +: SAMPLE_W];
        end
    endgenerate

    // Slot padding bits carry no sample data.
    assign unused_fifo_bits = ^fifo_dout;

    assign start  = (state_q == IDLE) && play_en && (play_len != 32'd0);
    assign run_ok = (state_q == RUN) && play_en;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: zero-length requests finish at once, enable low aborts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (play_en) state_d = (play_len == 32'd0) ? DONE : RUN;
            RUN: begin
                if (!play_en)                   state_d = IDLE;
                else if (remaining_q == 32'd0)  state_d = DONE;
            end
            DONE: if (!play_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: status word and single-outstanding FIFO read request.
    always_comb begin
        play_end   = {31'b0, state_q == DONE};
        fifo_rd_en = run_ok && (remaining_q != 32'd0) && !next_full_q && !pend_q
                     && !fifo_empty && (fetch_q != 32'd0);
    end

    // Datapath next-state: fetch, buffer shuffle, sample release, underrun.
    always_comb begin
        remaining_d = remaining_q;
        fetch_d     = fetch_q;
        lane_d      = lane_q;
        cur_d       = cur_q;
        next_d      = next_q;
        cur_full_d  = cur_full_q;
        next_full_d = next_full_q;
        pend_d      = pend_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        underrun_d  = underrun_q;

        if (start) begin
            remaining_d = play_len;
            fetch_d     = words_for(play_len, LANES);
            lane_d      = '0;
            cur_full_d  = 1'b0;
            next_full_d = 1'b0;
            pend_d      = 1'b0;
            underrun_d  = 1'b0;
        end else if (!run_ok) begin
            // Idle, done or aborting: drop buffers, counters and any read in
            // flight so a late FIFO word cannot leak into the next run.
            remaining_d = '0;
            fetch_d     = '0;
            lane_d      = '0;
            cur_full_d  = 1'b0;
            next_full_d = 1'b0;
            pend_d      = 1'b0;
        end else begin
            if (fifo_rd_en) begin
                pend_d  = 1'b1;
                fetch_d = fetch_q - 32'd1;
            end

            if (sample_tick && (remaining_q != 32'd0)) begin
                if (cur_full_q) begin
                    sample_d    = cur_lane[lane_q];
                    valid_d     = 1'b1;
                    remaining_d = remaining_q - 32'd1;
                    if (lane_q == LANE_LAST) begin
                        // Refill in the same cycle so back-to-back ticks never gap.
                        cur_full_d = next_full_q;
                        if (next_full_q) begin
                            cur_d       = next_q;
                            next_full_d = 1'b0;
                        end
                        lane_d = '0;
                    end else begin
                        lane_d = lane_q + LIDX_W'(1);
                    end
                end else begin
                    underrun_d = 1'b1;
                end
            end

            if (!cur_full_q && next_full_q) begin
                cur_d       = next_q;
                cur_full_d  = 1'b1;
                next_full_d = 1'b0;
                lane_d      = '0;
            end

            // The returning FIFO word always lands in next; next is known empty
            // here because a read is only issued while next is empty.
            if (fifo_valid && pend_q) begin
                next_d      = fifo_samples;
                next_full_d = 1'b1;
                pend_d      = 1'b0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_q <= '0;
            fetch_q     <= '0;
            lane_q      <= '0;
            cur_q       <= '0;
            next_q      <= '0;
            cur_full_q  <= 1'b0;
            next_full_q <= 1'b0;
            pend_q      <= 1'b0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            remaining_q <= remaining_d;
            fetch_q     <= fetch_d;
            lane_q      <= lane_d;
            cur_q       <= cur_d;
            next_q      <= next_d;
            cur_full_q  <= cur_full_d;
            next_full_q <= next_full_d;
            pend_q      <= pend_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_sample_playback.sv
// Directed bench for sample_playback: a FIFO model feeds packed words, the
// stimulus pushes expected samples into a scoreboard queue and a monitor
// pops and compares each sample_valid pulse.
module tb_sample_playback;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        play_en = 1'b0;
    logic [31:0] play_len = 32'd0;
    logic        sample_tick = 1'b0;
    logic [63:0] fifo_dout = 64'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_valid = 1'b0;
    logic        fifo_rd_en;
    logic [11:0] sample_out;
    logic        sample_valid;
    logic        underrun;
    logic [31:0] play_end;

    logic [63:0] fq [$];
    logic [11:0] exp_q [$];
    int checks = 0;
    int passed = 0;
    int sample_cnt = 0;
    int rd_cnt = 0;

    sample_playback dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .play_en      (play_en),
        .play_len     (play_len),
        .sample_tick  (sample_tick),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_valid   (fifo_valid),
        .fifo_rd_en   (fifo_rd_en),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .underrun     (underrun),
        .play_end     (play_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Standard FIFO model: data and valid appear one cycle after the read.
    always @(posedge clk) begin
        fifo_valid <= 1'b0;
        if (rst_n && fifo_rd_en) begin
            rd_cnt++;
            check("rd_while_empty", 64'(fifo_empty), 64'd0);
            if (fq.size() > 0) begin
                fifo_dout  <= fq.pop_front();
                fifo_valid <= 1'b1;
            end
            fifo_empty <= (fq.size() == 0);
        end
    end

    // Scoreboard monitor: one compare per delivered sample.
    always @(negedge clk) begin
        if (rst_n && sample_valid) begin
            sample_cnt++;
            $display("sample %03h at %0t", sample_out, $time);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_sample: got %03h expected none", sample_out);
            end else begin
                check("sample", 64'(sample_out), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic push(input logic [63:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic flush();
        fq.delete();
        fifo_empty = 1'b1;
    endtask

    task automatic expect_word(input logic [63:0] w, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(w[16*k +: 12]);
    endtask

    task automatic start(input logic [31:0] len);
        play_len = len;
        play_en  = 1'b1;
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic stop();
        play_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sample_out", 64'(sample_out), 64'd0);
        check("rst_sample_valid", 64'(sample_valid), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        check("rst_play_end", 64'(play_end), 64'd0);
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        rst_n = 1'b1;

        // Stays idle with data available until enabled.
        push(64'h0123_4567_89AB_CDEF);
        repeat (5) @(negedge clk);
        check("idle_no_read", 64'(rd_cnt), 64'd0);
        flush();

        // Basic single word.
        $display("scenario basic");
        push(64'h0ABC_0123_0456_0789);
        expect_word(64'h0ABC_0123_0456_0789, 4);
        start(32'd4);
        repeat (10) @(negedge clk);
        ticks(4, 10);
        repeat (5) @(negedge clk);
        check("basic_count", 64'(sample_cnt), 64'd4);
        check("basic_sb_empty", 64'(exp_q.size()), 64'd0);
        check("basic_play_end", 64'(play_end), 64'd1);
        check("basic_underrun", 64'(underrun), 64'd0);
        check("basic_hold", 64'(sample_out), 64'hABC);
        check("basic_reads", 64'(rd_cnt), 64'd1);
        stop();
        check("basic_idle_end", 64'(play_end), 64'd0);

        // Partial final word; an extra FIFO word must never be fetched.
        $display("scenario partial");
        sample_cnt = 0; rd_cnt = 0;
        push(64'h0222_0111_0BBB_0AAA);
        push(64'hFDDD_ECCC_BFFF_AEEE);
        push(64'h0999_0888_0777_0666);
        expect_word(64'h0222_0111_0BBB_0AAA, 4);
        expect_word(64'hFDDD_ECCC_BFFF_AEEE, 2);
        start(32'd6);
        repeat (10) @(negedge clk);
        ticks(6, 10);
        repeat (5) @(negedge clk);
        check("partial_count", 64'(sample_cnt), 64'd6);
        check("partial_reads", 64'(rd_cnt), 64'd2);
        check("partial_sb_empty", 64'(exp_q.size()), 64'd0);
        check("partial_play_end", 64'(play_end), 64'd1);
        stop();
        flush();

        // Underrun then resume.
        $display("scenario underrun");
        sample_cnt = 0; rd_cnt = 0;
        push(64'h0F0E_0D0C_0B0A_0908);
        expect_word(64'h0F0E_0D0C_0B0A_0908, 4);
        expect_word(64'h0765_0432_0CBA_0FED, 4);
        start(32'd8);
        repeat (10) @(negedge clk);
        ticks(4, 10);
        check("ur_before", 64'(underrun), 64'd0);
        ticks(1, 10);
        check("ur_set", 64'(underrun), 64'd1);
        check("ur_no_sample", 64'(sample_cnt), 64'd4);
        push(64'h0765_0432_0CBA_0FED);
        repeat (10) @(negedge clk);
        ticks(4, 10);
        repeat (5) @(negedge clk);
        check("ur_count", 64'(sample_cnt), 64'd8);
        check("ur_sticky", 64'(underrun), 64'd1);
        check("ur_play_end", 64'(play_end), 64'd1);
        check("ur_sb_empty", 64'(exp_q.size()), 64'd0);
        stop();
        flush();

        // Abort with a read in flight, then restart.
        $display("scenario abort");
        sample_cnt = 0; rd_cnt = 0;
        push(64'h0A03_0A02_0A01_0A00);
        expect_word(64'h0A03_0A02_0A01_0A00, 3);
        start(32'd8);
        repeat (10) @(negedge clk);
        ticks(3, 10);
        push(64'h0B03_0B02_0B01_0B00);
        @(negedge clk);
        check("abort_read_issued", 64'(rd_cnt), 64'd2);
        play_en = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_idle", 64'(play_end), 64'd0);
        check("abort_count", 64'(sample_cnt), 64'd3);
        check("abort_sb_empty", 64'(exp_q.size()), 64'd0);
        push(64'h0C03_0C02_0C01_0C00);
        expect_word(64'h0C03_0C02_0C01_0C00, 4);
        start(32'd4);
        repeat (10) @(negedge clk);
        ticks(4, 10);
        repeat (5) @(negedge clk);
        check("restart_count", 64'(sample_cnt), 64'd7);
        check("restart_reads", 64'(rd_cnt), 64'd3);
        check("restart_play_end", 64'(play_end), 64'd1);
        check("restart_underrun", 64'(underrun), 64'd0);
        stop();
        flush();

        // Zero length goes straight to DONE; ticks there are ignored.
        $display("scenario zero_len");
        sample_cnt = 0; rd_cnt = 0;
        push(64'h0123_0123_0123_0123);
        start(32'd0);
        @(negedge clk);
        check("zero_done", 64'(play_end), 64'd1);
        ticks(1, 4);
        check("zero_reads", 64'(rd_cnt), 64'd0);
        check("zero_no_sample", 64'(sample_cnt), 64'd0);
        check("zero_no_underrun", 64'(underrun), 64'd0);
        stop();
        flush();

        // Ticks every cycle across a lane-3 consume with next already full.
        $display("scenario back_to_back");
        sample_cnt = 0; rd_cnt = 0;
        push(64'h0D44_0D33_0D22_0D11);
        push(64'h0E44_0E33_0E22_0E11);
        expect_word(64'h0D44_0D33_0D22_0D11, 4);
        expect_word(64'h0E44_0E33_0E22_0E11, 4);
        start(32'd8);
        repeat (15) @(negedge clk);
        ticks(8, 1);
        repeat (5) @(negedge clk);
        check("b2b_count", 64'(sample_cnt), 64'd8);
        check("b2b_underrun", 64'(underrun), 64'd0);
        check("b2b_play_end", 64'(play_end), 64'd1);
        check("b2b_sb_empty", 64'(exp_q.size()), 64'd0);
        stop();
        flush();

        // Asynchronous reset in the middle of a run.
        $display("scenario reset_mid_run");
        sample_cnt = 0; rd_cnt = 0;
        push(64'h0A03_0A02_0A01_0A00);
        expect_word(64'h0A03_0A02_0A01_0A00, 4);
        start(32'd8);
        repeat (10) @(negedge clk);
        ticks(5, 10);
        check("mr_underrun_pre", 64'(underrun), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("mr_sample_out", 64'(sample_out), 64'd0);
        check("mr_sample_valid", 64'(sample_valid), 64'd0);
        check("mr_underrun", 64'(underrun), 64'd0);
        check("mr_play_end", 64'(play_end), 64'd0);
        check("mr_rd_en", 64'(fifo_rd_en), 64'd0);
        play_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push(64'h0555_0555_0555_0555);
        repeat (5) @(negedge clk);
        check("mr_idle_reads", 64'(rd_cnt), 64'd1);
        check("mr_idle_end", 64'(play_end), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
